// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int PORT_W  = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

   // One-hot decode of a requester index.
   function automatic logic [NUM_REQ-1:0] onehot_of(input logic [PORT_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: finds the first masked request at or after
// ptr (modulo 8) by rotating the request vector, priority-encoding the
// lowest set bit, and rotating the index back.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PORT_W-1:0]  ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic               any,
   output logic [PORT_W-1:0]  win
);

   // Rotate so bit 0 is the pointer position, encode, then un-rotate.
   always_comb begin
      logic [NUM_REQ-1:0] masked;
      logic [NUM_REQ-1:0] rot;
      logic [PORT_W-1:0]  src;
      logic [PORT_W-1:0]  idx;
      // NOTE: every variable gets a value before any conditional logic so
      // no path leaves it unassigned, which would infer a latch.
      masked = req & mask;
      rot    = '0;
      src    = '0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src    = ptr + PORT_W'(i);
         rot[i] = masked[src];
      end
      // Scan downwards so the lowest rotated bit (closest to ptr) wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) idx = PORT_W'(i);
      end
      any = |masked;
      win = ptr + idx;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold time. Drives a one-hot
// grant, a binary mux select and a busy flag, all straight from registers.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [PORT_W-1:0]  port,
   output logic               busy
);

   localparam int              HC_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
   localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(1);

   arb_state_t         state_q, state_d;
   logic [PORT_W-1:0]  owner_q, owner_d;
   logic [PORT_W-1:0]  ptr_q, ptr_d;
   logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               busy_q, busy_d;

   logic               owner_rel;
   logic               at_limit;
   logic               forced;
   logic [NUM_REQ-1:0] pick_mask;
   logic               pick_any;
   logic [PORT_W-1:0]  pick_win;

   // Forced rotation masks the owner out; otherwise every requester competes.
   always_comb begin
      owner_rel = ~req[owner_q];
      at_limit  = (hold_cnt_q == HOLD_MAX);
      forced    = (state_q == GRANT) && !owner_rel && at_limit;
      pick_mask = forced ? ~onehot_of(owner_q) : '1;
   end

   rr_pick8 u_pick (
      .req  (req),
      .ptr  (ptr_q),
      .mask (pick_mask),
      .any  (pick_any),
      .win  (pick_win)
   );

   // Next-state, owner, pointer and hold counter; outputs follow the next state.
   always_comb begin
      logic take;
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      take       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) take = 1'b1;
         end
         GRANT: begin
            if (owner_rel) begin
               // Release wins over an expired hold; hand off with no bubble.
               if (pick_any) take = 1'b1;
               else          state_d = IDLE;
            end else if (at_limit) begin
               if (pick_any) take = 1'b1;
               else          hold_cnt_d = HOLD_ONE;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (take) begin
         state_d    = GRANT;
         owner_d    = pick_win;
         ptr_d      = pick_win + PORT_W'(1);
         hold_cnt_d = HOLD_ONE;
      end

      grant_d = (state_d == GRANT) ? onehot_of(owner_d) : '0;
      busy_d  = (state_d == GRANT);
   end

   // State and output registers; synchronous reset has priority over everything.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
      end
   end

   assign grant = grant_q;
   assign port  = owner_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios followed by random
// traffic, all compared against a request-level round-robin model.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] port;
   logic       busy;

   int n_cmp;
   int n_err;

   // Reference model state (plain integers).
   int m_busy;
   int m_owner;
   int m_ptr;
   int m_cnt;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant),
      .port  (port),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // First requester at or after p (mod 8) that is set and is not excl.
   function automatic int pick(input logic [7:0] r, input int p, input int excl);
      for (int k = 0; k < 8; k++) begin
         int i;
         i = (p + k) % 8;
         if (i != excl && r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_take(input int w);
      m_busy  = 1;
      m_owner = w;
      m_ptr   = (w + 1) % 8;
      m_cnt   = 1;
   endtask

   task automatic model_step(input logic [7:0] r, input logic rst);
      int w;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end else if (m_busy == 0) begin
         w = pick(r, m_ptr, -1);
         if (w >= 0) model_take(w);
      end else if (!r[m_owner]) begin
         w = pick(r, m_ptr, -1);
         if (w >= 0) model_take(w);
         else        m_busy = 0;
      end else if (m_cnt == MAX_HOLD) begin
         w = pick(r, m_ptr, m_owner);
         if (w >= 0) model_take(w);
         else        m_cnt = 1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [7:0] exp_grant;
      exp_grant = (m_busy != 0) ? (8'h01 << m_owner) : 8'h00;
      check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
      check({tag, ".port"},  32'(port),  32'(m_owner));
      check({tag, ".busy"},  32'(busy),  32'(m_busy));
      check({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
      if (m_busy != 0) check({tag, ".hold"}, 32'(dut.hold_cnt_q), 32'(m_cnt));
   endtask

   // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
   task automatic tick(input string tag, input logic [7:0] r, input logic rst);
      req   = r;
      reset = rst;
      @(posedge clk);
      model_step(r, rst);
      #1;
      compare_all(tag);
   endtask

   initial begin
      logic [7:0] r;
      n_cmp = 0; n_err = 0;
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      reset = 1'b1;
      req   = 8'h00;

      // Reset held two cycles with every requester active.
      tick("reset0", 8'hFF, 1'b1);
      tick("reset1", 8'hFF, 1'b1);
      check("reset.grant_lit", 32'(grant), 32'h0);
      // All requesting: forced rotation 01 x4, 02 x4, ... 80 x4, back to 01.
      for (int i = 0; i < 8 * MAX_HOLD + 2; i++) tick("rotate", 8'hFF, 1'b0);
      check("rotate.wrap_grant", 32'(grant), 32'h01);

      // Single request then release; port holds through idle.
      tick("single_rst", 8'h00, 1'b1);
      tick("single_on", 8'h04, 1'b0);
      check("single.grant_lit", 32'(grant), 32'h04);
      tick("single_off", 8'h00, 1'b0);
      check("single.port_hold", 32'(port), 32'd2);

      // Direct handoff 0 -> 7 with no bubble, then pointer wrap to 0.
      tick("hand_rst", 8'h00, 1'b1);
      tick("hand_a", 8'h81, 1'b0);
      tick("hand_b", 8'h80, 1'b0);
      check("hand.grant_lit", 32'(grant), 32'h80);
      tick("hand_c", 8'h00, 1'b0);
      check("hand.ptr_wrap", 32'(dut.ptr_q), 32'd0);

      // Lone long request keeps the grant; counter cycles 1..MAX_HOLD.
      tick("lone_rst", 8'h00, 1'b1);
      for (int i = 0; i < 20; i++) tick("lone", 8'h10, 1'b0);

      // Reset mid-grant, then requester 0 wins over 5.
      tick("mid_rst", 8'h00, 1'b1);
      tick("mid_g", 8'h20, 1'b0);
      tick("mid_hold", 8'h20, 1'b0);
      tick("mid_reset", 8'h21, 1'b1);
      tick("mid_after", 8'h21, 1'b0);
      check("mid.grant_lit", 32'(grant), 32'h01);

      // Random traffic with occasional resets.
      r = 8'h00;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'h01 << $urandom_range(0, 7);
            2:       r = r;
            default: r = 8'($urandom);
         endcase
         tick("rand", r, ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
